icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves fetch's next-PC address with a same-cycle instruction on a hit.
- On a miss: asserts stall, refills one 4-word line from the memory port via a burst FSM, then serves the instruction.
- Supports whole-cache invalidation for fence.i.

Parameters:
- XLEN, riscv_pkg::XLEN, address width.
- LINES, 16, number of cache lines; power of 2, minimum 2.
- WORDS, 4, 32-bit words per line; power of 2, minimum 2.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- adr_i  in  XLEN  fetch address; bits [1:0] ignored
- instr_o  out  32  instruction at adr_i; valid when stall_o=0
- stall_o  out  1  miss in progress; requester holds adr_i and does not advance
- inval_i  in  1  one-cycle pulse that invalidates all lines
- mem_req_o  out  1  line refill request
- mem_adr_o  out  XLEN  line-aligned refill address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  refill beat valid
- mem_rdata_i  in  32  refill beat data, words in ascending address order

Behaviour:
- Address split:
  - offset = adr[2+:log2(WORDS)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - valid[LINES], tag[LINES], data[LINES][WORDS], all flops.
  - Only valid resets; tag and data have no reset.
- Reset values: instr_o=0x00000013 (NOP), stall_o=0, mem_req_o=0, mem_adr_o=0, all valid=0, FSM=IDLE.
- Hit = valid[index] and tag[index]==tag. Lookup is combinational, zero latency.
- instr_o:
  - hit: data[index][offset]
  - otherwise: 0x00000013
- FSM states: IDLE, REQ, REFILL, DONE.
  - IDLE: on a miss, latch miss address in miss_adr_q and go to REQ. stall_o=1 in the same cycle (combinational from the miss).
  - REQ: mem_req_o=1, mem_adr_o = miss_adr_q with offset and byte bits zeroed. Hold both stable until mem_gnt_i=1, then go to REFILL with beat counter=0.
  - REFILL: each mem_rvalid_i=1 writes mem_rdata_i into data[miss index][counter] and increments the counter. The beat with counter==WORDS-1 writes the tag, sets valid (unless killed) and goes to DONE. Gaps in mem_rvalid_i are allowed.
  - DONE: one cycle with stall_o=1, then return to IDLE. Lookup repeats on the current adr_i.
- stall_o = (IDLE and miss) or state!=IDLE.
- mem_rvalid_i in IDLE or REQ is ignored.
- inval_i:
  - Clears all valid bits in the next cycle.
  - If asserted during REQ or REFILL, set a kill flag. The refill completes all beats but does not set valid. The kill flag clears in DONE. Result: a second miss and refill on the same address.
  - If inval_i coincides with the final beat, valid stays 0.
- Requester changes adr_i mid-miss (branch flush): the refill of the latched line completes. After DONE, the new adr_i is looked up normally. No abort of the memory transaction.
- A refill overwrites the line at its index (conflict eviction); no writeback.
- Counter wraps to 0 on completion; width log2(WORDS).
- Asynchronous reset during any state: immediately to IDLE, all valid=0, mem_req_o=0. Beats arriving after reset are ignored.

Decomposition:
- riscv_pkg gains:
  - NOP_INSTR = 32'h00000013
  - icache_state_t enum {IDLE, REQ, REFILL, DONE}
- Local parameters for INDEX_W, OFFSET_W, TAG_W are derived inside the module.
- One natural sub-module: icache_refill_fsm, holding the state, beat counter, kill flag and memory handshake. Tag/data arrays and hit logic stay in the top.

Test Plan:
- Cold miss: reset, adr_i=0x1000; memory grants after 2 cycles, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> stall_o=1 for 1+2+4+1 cycles, mem_adr_o=0x1000, then instr_o=0x000000A0. adr_i=0x100C next cycle -> hit, instr_o=0x000000A3, stall_o=0.
- Conflict eviction: fill 0x1000, then access 0x1100 (same index, LINES=16, WORDS=4) -> miss, refill. Re-access 0x1000 -> miss again.
- Gapped beats: mem_rvalid_i pattern 1,0,0,1,1,0,1 -> all 4 words correct. FSM stays in REFILL until the 4th valid beat.
- Invalidate mid-refill: inval_i pulse after beat 1 -> refill completes, line not valid, same adr_i misses again. Invalidate in IDLE -> all previously filled lines miss.
- adr_i changes to 0x2000 during REFILL of 0x1000 -> 0x1000 line filled and valid, then a new miss and request for 0x2000.
- Async reset asserted in REFILL after 2 beats -> outputs at reset values immediately. Stray mem_rvalid_i after reset ignored. 0x1000 misses after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: address width, canonical NOP and
// the instruction-cache refill FSM state encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2,
        DONE   = 2'd3
    } icache_state_t;

endpackage

// File: rtl/icache_dm_if.sv
// Instruction-cache line-refill bus: request/grant then a burst of
// read beats. master = cache (req, adr out), slave = memory.
interface icache_dm_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);

    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_adr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_adr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/icache_dm_refill_fsm.sv
// Refill engine: latches the missing line, runs req/gnt and counts
// beats. Ports: clk, reset_n, i_miss/i_inval/i_line in, mem bus,
// o_state, o_line, o_beat, o_beat_we, o_fill_done, o_set_valid out.
module icache_refill_fsm
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned WORDS = 4,
    localparam int unsigned OFFSET_W = $clog2(WORDS),
    localparam int unsigned LINE_W   = XLEN - 2 - OFFSET_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_miss,
    input  logic                i_inval,
    input  logic [LINE_W-1:0]   i_line,
    icache_dm_if.master         mem,
    output icache_state_t       o_state,
    output logic [LINE_W-1:0]   o_line,
    output logic [OFFSET_W-1:0] o_beat,
    output logic                o_beat_we,
    output logic                o_fill_done,
    output logic                o_set_valid
);

    localparam logic [OFFSET_W-1:0] LAST_BEAT =
        OFFSET_W'(WORDS - 1);

    icache_state_t       r_state;
    logic [LINE_W-1:0]   r_line;
    logic [OFFSET_W-1:0] r_beat;
    logic                r_kill;
    logic                w_beat_we;
    logic                w_last;

    assign w_beat_we = (r_state == REFILL)
                     && mem.mem_rvalid_i;
    assign w_last    = w_beat_we && (r_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_beat  <= '0;
            r_kill  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_miss) begin
                        r_state <= REQ;
                        r_line  <= i_line;
                    end
                end
                REQ: begin
                    if (i_inval) r_kill <= 1'b1;
                    if (mem.mem_gnt_i) begin
                        r_state <= REFILL;
                        r_beat  <= '0;
                    end
                end
                REFILL: begin
                    if (i_inval) r_kill <= 1'b1;
                    if (w_beat_we) r_beat <= r_beat + 1'b1;
                    if (w_last) r_state <= DONE;
                end
                DONE: begin
                    r_kill  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req_o = (r_state == REQ);
    assign mem.mem_adr_o = (r_state == REQ)
        ? {r_line, {(OFFSET_W + 2){1'b0}}}
        : '0;

    assign o_state     = r_state;
    assign o_line      = r_line;
    assign o_beat      = r_beat;
    assign o_beat_we   = w_beat_we;
    assign o_fill_done = w_last;
    // An invalidate on the final beat must win over the fill.
    assign o_set_valid = w_last && !r_kill && !i_inval;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache. Ports: clk, reset_n, adr_i in;
// instr_o, stall_o out; inval_i in; mem = refill bus (master).
module icache_dm
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] adr_i,
    output logic [31:0]     instr_o,
    output logic            stall_o,
    input  logic            inval_i,
    icache_dm_if.master     mem
);

    localparam int unsigned OFFSET_W = $clog2(WORDS);
    localparam int unsigned INDEX_W  = $clog2(LINES);
    localparam int unsigned TAG_W    = XLEN - 2 - OFFSET_W - INDEX_W;
    localparam int unsigned LINE_W   = XLEN - 2 - OFFSET_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];

    logic [OFFSET_W-1:0] w_offset;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_unused;

    icache_state_t       w_state;
    logic [LINE_W-1:0]   w_m_line;
    logic [INDEX_W-1:0]  w_m_index;
    logic [TAG_W-1:0]    w_m_tag;
    logic [OFFSET_W-1:0] w_beat;
    logic                w_beat_we;
    logic                w_fill_done;
    logic                w_set_valid;

    assign w_offset = adr_i[2 +: OFFSET_W];
    assign w_index  = adr_i[2 + OFFSET_W +: INDEX_W];
    assign w_tag    = adr_i[XLEN-1 -: TAG_W];
    assign w_unused = ^adr_i[1:0];

    assign w_hit = r_valid[w_index]
                && (r_tag[w_index] == w_tag);

    assign instr_o = w_hit ? r_data[w_index][w_offset]
                           : NOP_INSTR;

    // Held low in reset even though every line reads as a miss.
    assign stall_o = reset_n
        && ((w_state != IDLE) || !w_hit);

    assign w_m_index = w_m_line[INDEX_W-1:0];
    assign w_m_tag   = w_m_line[LINE_W-1 -: TAG_W];

    icache_refill_fsm #(
        .XLEN  (XLEN),
        .WORDS (WORDS)
    ) u_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_miss      (!w_hit),
        .i_inval     (inval_i),
        .i_line      (adr_i[XLEN-1:OFFSET_W+2]),
        .mem         (mem),
        .o_state     (w_state),
        .o_line      (w_m_line),
        .o_beat      (w_beat),
        .o_beat_we   (w_beat_we),
        .o_fill_done (w_fill_done),
        .o_set_valid (w_set_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (inval_i) begin
            r_valid <= '0;
        end else if (w_set_valid) begin
            r_valid[w_m_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_beat_we) begin
            r_data[w_m_index][w_beat] <= mem.mem_rdata_i;
        end
        if (w_fill_done) begin
            r_tag[w_m_index] <= w_m_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, eviction, gapped beats,
// invalidation, mid-miss address change and reset during refill.
module tb_icache_dm;
    import riscv_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] adr     = '0;
    logic [31:0] instr;
    logic        stall;
    logic        inval   = 1'b0;

    int checks = 0;
    int errors = 0;

    icache_dm_if mem_if ();

    icache_dm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .adr_i   (adr),
        .instr_o (instr),
        .stall_o (stall),
        .inval_i (inval),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] ei,
                        input logic es);
        adr = a;
        #1;
        chk({tag, ".instr"}, instr, ei);
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, es});
    endtask

    // Entered in IDLE with a miss pending on adr; leaves in IDLE.
    task automatic serve(input string tag,
                         input logic [31:0] line_adr,
                         input int gwait,
                         input logic [15:0] vpat,
                         input int plen,
                         input logic [31:0] dbase,
                         input int inval_at,
                         input int chg_at,
                         input logic [31:0] chg_adr);
        int n;
        int k;
        n = 0;
        k = 0;
        #1;
        n += int'(stall);
        cyc();
        chk({tag, ".req"}, {31'b0, mem_if.mem_req_o}, 32'd1);
        chk({tag, ".madr"}, mem_if.mem_adr_o, line_adr);
        for (int i = 0; i < gwait; i++) begin
            n += int'(stall);
            cyc();
        end
        chk({tag, ".madr_hold"}, mem_if.mem_adr_o, line_adr);
        mem_if.mem_gnt_i = 1'b1;
        n += int'(stall);
        cyc();
        mem_if.mem_gnt_i = 1'b0;
        for (int i = 0; i < plen; i++) begin
            mem_if.mem_rvalid_i = vpat[i];
            mem_if.mem_rdata_i  = vpat[i] ? dbase + 32'(k)
                                          : 32'hDEAD_BEEF;
            inval = (i == inval_at);
            if (i == chg_at) adr = chg_adr;
            #1;
            n += int'(stall);
            cyc();
            k += int'(vpat[i]);
        end
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        inval = 1'b0;
        chk({tag, ".done_req"},
            {31'b0, mem_if.mem_req_o}, 32'd0);
        n += int'(stall);
        cyc();
        chk({tag, ".nstall"}, 32'(n), 32'(3 + gwait + plen));
    endtask

    initial begin
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        adr = 32'h1000;
        repeat (2) cyc();
        chk("rst.instr", instr, NOP_INSTR);
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk("rst.req", {31'b0, mem_if.mem_req_o}, 32'd0);
        chk("rst.madr", mem_if.mem_adr_o, 32'd0);
        reset_n = 1'b1;

        serve("cold", 32'h1000, 1, 16'hF, 4, 32'hA0,
              -1, -1, '0);
        look("cold0", 32'h1000, 32'hA0, 1'b0);
        look("cold3", 32'h100C, 32'hA3, 1'b0);

        look("conf_miss", 32'h1100, NOP_INSTR, 1'b1);
        serve("conf", 32'h1100, 0, 16'hF, 4, 32'hB0,
              -1, -1, '0);
        look("conf1", 32'h1104, 32'hB1, 1'b0);
        look("evict", 32'h1000, NOP_INSTR, 1'b1);
        serve("refill0", 32'h1000, 0, 16'hF, 4, 32'hC0,
              -1, -1, '0);
        look("re0", 32'h1000, 32'hC0, 1'b0);

        look("gap_miss", 32'h2040, NOP_INSTR, 1'b1);
        serve("gap", 32'h2040, 0, 16'b1011001, 7, 32'hD0,
              -1, -1, '0);
        look("gap0", 32'h2040, 32'hD0, 1'b0);
        look("gap1", 32'h2044, 32'hD1, 1'b0);
        look("gap2", 32'h2048, 32'hD2, 1'b0);
        look("gap3", 32'h204C, 32'hD3, 1'b0);

        inval = 1'b1;
        cyc();
        inval = 1'b0;
        look("inv_1000", 32'h1000, NOP_INSTR, 1'b1);
        look("inv_2040", 32'h2040, NOP_INSTR, 1'b1);
        serve("inv_idle", 32'h2040, 0, 16'hF, 4, 32'hE0,
              -1, -1, '0);
        look("inv_ok", 32'h2040, 32'hE0, 1'b0);

        look("kill_miss", 32'h1000, NOP_INSTR, 1'b1);
        serve("kill", 32'h1000, 0, 16'hF, 4, 32'hF0,
              2, -1, '0);
        look("kill_again", 32'h1000, NOP_INSTR, 1'b1);
        serve("rekill", 32'h1000, 2, 16'hF, 4, 32'h50,
              -1, -1, '0);
        look("refilled", 32'h1000, 32'h50, 1'b0);

        look("last_miss", 32'h1010, NOP_INSTR, 1'b1);
        serve("last", 32'h1010, 0, 16'hF, 4, 32'h60,
              3, -1, '0);
        look("last_inv", 32'h1010, NOP_INSTR, 1'b1);
        look("all_inv", 32'h1000, NOP_INSTR, 1'b1);
        look("last_inv2", 32'h1010, NOP_INSTR, 1'b1);
        serve("last_re", 32'h1010, 0, 16'hF, 4, 32'h70,
              -1, -1, '0);
        look("last_ok", 32'h1014, 32'h71, 1'b0);

        look("br_miss", 32'h1000, NOP_INSTR, 1'b1);
        serve("br", 32'h1000, 0, 16'hF, 4, 32'h80,
              -1, 1, 32'h2000);
        look("br_new", 32'h2000, NOP_INSTR, 1'b1);
        look("br_old", 32'h1008, 32'h82, 1'b0);
        look("br_new2", 32'h2000, NOP_INSTR, 1'b1);
        serve("br2", 32'h2000, 0, 16'hF, 4, 32'h90,
              -1, -1, '0);
        look("br2_ok", 32'h2000, 32'h90, 1'b0);

        look("rr_miss", 32'h3030, NOP_INSTR, 1'b1);
        cyc();
        mem_if.mem_gnt_i = 1'b1;
        cyc();
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'h11;
        cyc();
        mem_if.mem_rdata_i = 32'h12;
        cyc();
        chk("rr.pre_stall", {31'b0, stall}, 32'd1);
        reset_n = 1'b0;
        mem_if.mem_rdata_i = 32'h99;
        #1;
        chk("rr.stall", {31'b0, stall}, 32'd0);
        chk("rr.req", {31'b0, mem_if.mem_req_o}, 32'd0);
        chk("rr.madr", mem_if.mem_adr_o, 32'd0);
        chk("rr.instr", instr, NOP_INSTR);
        cyc();
        adr = 32'h1000;
        reset_n = 1'b1;
        #1;
        chk("rr.miss", {31'b0, stall}, 32'd1);
        chk("rr.idle_req",
            {31'b0, mem_if.mem_req_o}, 32'd0);
        cyc();
        chk("rr.req2", {31'b0, mem_if.mem_req_o}, 32'd1);
        chk("rr.madr2", mem_if.mem_adr_o, 32'h1000);
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_gnt_i    = 1'b1;
        cyc();
        mem_if.mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_rvalid_i = 1'b1;
            mem_if.mem_rdata_i  = 32'h21 + 32'(i);
            cyc();
        end
        mem_if.mem_rvalid_i = 1'b0;
        chk("rr.done", {31'b0, stall}, 32'd1);
        cyc();
        look("rr_fill0", 32'h1000, 32'h21, 1'b0);
        look("rr_fill3", 32'h100C, 32'h24, 1'b0);
        look("rr_3030", 32'h3030, NOP_INSTR, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
